// File: rtl/multdiv_tracker_if.sv
// Bundle of X-stage, multdiv and writeback signals seen by the multdiv issue/tracking controller.
interface multdiv_tracker_if;
    logic [31:0] dx_insn;
    logic        dx_valid;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic        multOngoing;
    logic [31:0] inM;
    logic        issue_stall;
    logic        wb_req;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ack;

    // Tracker side
    modport slave (
        input  dx_insn, dx_valid, data_resultRDY, data_result, data_exception, wb_ack,
        output ctrl_MULT, ctrl_DIV, multOngoing, inM, issue_stall, wb_req, wb_rd, wb_data
    );

    // Pipeline / multdiv / writeback side
    modport master (
        output dx_insn, dx_valid, data_resultRDY, data_result, data_exception, wb_ack,
        input  ctrl_MULT, ctrl_DIV, multOngoing, inM, issue_stall, wb_req, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_tracker.sv
// Issue/tracking controller for the iterative multdiv unit in the X stage.
// Starts mul/div, tracks the in-flight instruction, times out a silent unit,
// and presents the result (or rstatus exception code) on the writeback port.
module multdiv_tracker #(
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned STATUS_REG   = 30,
    parameter int unsigned MUL_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE = 5
) (
    input  logic              clock,
    input  logic              reset,
    multdiv_tracker_if.slave  md
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [1:0]       state_q, state_d;
    logic [31:0]      inm_q, inm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             exc_q, exc_d;

    logic is_mul, is_div, is_md, can_issue, issue, inm_is_mul;

    // Decode the X-stage instruction and decide whether it may start this cycle
    always_comb begin
        is_mul    = (md.dx_insn[31:27] == OP_ALU) && (md.dx_insn[6:2] == ALU_MUL);
        is_div    = (md.dx_insn[31:27] == OP_ALU) && (md.dx_insn[6:2] == ALU_DIV);
        is_md     = is_mul || is_div;
        can_issue = (state_q == S_IDLE) || ((state_q == S_DONE) && md.wb_ack);
        issue     = md.dx_valid && is_md && can_issue;
    end

    // State and tracking registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            inm_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inm_q   <= inm_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state logic: issue, completion/timeout, writeback retirement
    always_comb begin
        state_d = state_q;
        inm_d   = inm_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_BUSY;
                    inm_d   = md.dx_insn;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the last allowed cycle beats the timeout
                if (md.data_resultRDY) begin
                    state_d = S_DONE;
                    res_d   = md.data_result;
                    exc_d   = md.data_exception;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    res_d   = '0;
                    exc_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (md.wb_ack) begin
                    if (issue) begin
                        state_d = S_BUSY;
                        inm_d   = md.dx_insn;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        inm_d   = '0;
                    end
                    res_d = '0;
                    exc_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                inm_d   = '0;
                cnt_d   = '0;
                res_d   = '0;
                exc_d   = 1'b0;
            end
        endcase
    end

    // Start pulses, stall, tracking status and writeback payload
    always_comb begin
        inm_is_mul     = (inm_q[6:2] == ALU_MUL);
        md.ctrl_MULT   = issue && is_mul;
        md.ctrl_DIV    = issue && is_div;
        md.issue_stall = md.dx_valid && is_md && !can_issue;
        md.multOngoing = (state_q != S_IDLE);
        md.inM         = inm_q;
        md.wb_req      = 1'b0;
        md.wb_rd       = '0;
        md.wb_data     = '0;
        if (state_q == S_DONE) begin
            md.wb_req = 1'b1;
            if (exc_q) begin
                md.wb_rd   = 5'(STATUS_REG);
                md.wb_data = inm_is_mul ? 32'(MUL_EXC_CODE) : 32'(DIV_EXC_CODE);
            end else begin
                md.wb_rd   = inm_q[26:22];
                md.wb_data = res_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_tracker.sv
// Directed bench for multdiv_tracker: decode table plus multi-cycle sequences.
module tb_multdiv_tracker;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    multdiv_tracker_if md ();

    multdiv_tracker #(
        .TIMEOUT(64), .STATUS_REG(30), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .md    (md)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic [31:0] insn;
        logic        valid;
        logic        exp_mult;
        logic        exp_div;
        logic        exp_stall;
        logic        exp_ongoing;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
        return {op, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic quiet_inputs();
        md.dx_insn        = '0;
        md.dx_valid       = 1'b0;
        md.data_resultRDY = 1'b0;
        md.data_result    = '0;
        md.data_exception = 1'b0;
        md.wb_ack         = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        quiet_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Issue insn from IDLE and step into the first BUSY cycle
    task automatic issue_from_idle(input logic [31:0] insn);
        md.dx_insn  = insn;
        md.dx_valid = 1'b1;
        cyc();
        md.dx_valid = 1'b0;
    endtask

    vec_t vecs [8];
    logic [31:0] mul5, div7, mul3, mul4, mul9, div11, div12, mul6;
    int   bad;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mul5  = mk(5'b00000, 5'd5,  5'b00110);
        div7  = mk(5'b00000, 5'd7,  5'b00111);
        mul3  = mk(5'b00000, 5'd3,  5'b00110);
        mul4  = mk(5'b00000, 5'd4,  5'b00110);
        mul9  = mk(5'b00000, 5'd9,  5'b00110);
        div11 = mk(5'b00000, 5'd11, 5'b00111);
        div12 = mk(5'b00000, 5'd12, 5'b00111);
        mul6  = mk(5'b00000, 5'd6,  5'b00110);

        vecs[0] = '{mk(5'b00000, 5'd8, 5'b00000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // add
        vecs[1] = '{mk(5'b00000, 5'd8, 5'b00110), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // mul
        vecs[2] = '{mk(5'b00000, 5'd8, 5'b00111), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // div
        vecs[3] = '{mk(5'b00000, 5'd8, 5'b00110), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mul, bubble
        vecs[4] = '{mk(5'b00000, 5'd8, 5'b00111), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // div, bubble
        vecs[5] = '{mk(5'b00101, 5'd8, 5'b00110), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // non-ALU opcode
        vecs[6] = '{mk(5'b00000, 5'd8, 5'b00001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // sub
        vecs[7] = '{mk(5'b01000, 5'd8, 5'b00111), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // non-ALU opcode

        // Reset state
        do_reset();
        smp();
        chk("rst_ctrl_mult", 32'(md.ctrl_MULT),   32'd0);
        chk("rst_ctrl_div",  32'(md.ctrl_DIV),    32'd0);
        chk("rst_stall",     32'(md.issue_stall), 32'd0);
        chk("rst_ongoing",   32'(md.multOngoing), 32'd0);
        chk("rst_inm",       md.inM,              32'd0);
        chk("rst_wb_req",    32'(md.wb_req),      32'd0);
        chk("rst_wb_rd",     32'(md.wb_rd),       32'd0);
        chk("rst_wb_data",   md.wb_data,          32'd0);

        // Decode table, each vector applied from IDLE
        for (int i = 0; i < 8; i++) begin
            do_reset();
            md.dx_insn  = vecs[i].insn;
            md.dx_valid = vecs[i].valid;
            smp();
            chk($sformatf("vec%0d_ctrl_mult", i), 32'(md.ctrl_MULT),   32'(vecs[i].exp_mult));
            chk($sformatf("vec%0d_ctrl_div", i),  32'(md.ctrl_DIV),    32'(vecs[i].exp_div));
            chk($sformatf("vec%0d_stall", i),     32'(md.issue_stall), 32'(vecs[i].exp_stall));
            cyc();
            md.dx_valid = 1'b0;
            smp();
            chk($sformatf("vec%0d_ongoing", i),   32'(md.multOngoing), 32'(vecs[i].exp_ongoing));
        end

        // Mul rd=5, result 0x42 after 32 BUSY cycles
        do_reset();
        md.dx_insn  = mul5;
        md.dx_valid = 1'b1;
        smp();
        chk("t1_ctrl_mult", 32'(md.ctrl_MULT),   32'd1);
        chk("t1_ctrl_div",  32'(md.ctrl_DIV),    32'd0);
        chk("t1_ongoing0",  32'(md.multOngoing), 32'd0);
        cyc();
        md.dx_valid = 1'b0;
        smp();
        chk("t1_ongoing1",  32'(md.multOngoing), 32'd1);
        chk("t1_inm",       md.inM,              mul5);
        chk("t1_pulse_end", 32'(md.ctrl_MULT),   32'd0);
        repeat (31) cyc();
        md.data_resultRDY = 1'b1;
        md.data_result    = 32'h42;
        smp();
        chk("t1_no_req_busy", 32'(md.wb_req), 32'd0);
        cyc();
        md.data_resultRDY = 1'b0;
        md.data_result    = 32'hdead_beef;
        md.wb_ack         = 1'b1;
        smp();
        chk("t1_wb_req",  32'(md.wb_req),      32'd1);
        chk("t1_wb_rd",   32'(md.wb_rd),       32'd5);
        chk("t1_wb_data", md.wb_data,          32'h42);
        chk("t1_ack_ong", 32'(md.multOngoing), 32'd1);
        cyc();
        md.wb_ack = 1'b0;
        smp();
        chk("t1_idle_ong",  32'(md.multOngoing), 32'd0);
        chk("t1_idle_inm",  md.inM,              32'd0);
        chk("t1_idle_req",  32'(md.wb_req),      32'd0);

        // Div exception then mul exception
        do_reset();
        issue_from_idle(div7);
        md.data_resultRDY = 1'b1;
        md.data_exception = 1'b1;
        md.data_result    = 32'h1234;
        cyc();
        quiet_inputs();
        md.wb_ack = 1'b1;
        smp();
        chk("t2_div_req",  32'(md.wb_req), 32'd1);
        chk("t2_div_rd",   32'(md.wb_rd),  32'd30);
        chk("t2_div_data", md.wb_data,     32'd5);
        cyc();
        md.wb_ack = 1'b0;
        issue_from_idle(mul3);
        md.data_resultRDY = 1'b1;
        md.data_exception = 1'b1;
        cyc();
        quiet_inputs();
        smp();
        chk("t2_mul_rd",   32'(md.wb_rd), 32'd30);
        chk("t2_mul_data", md.wb_data,    32'd4);

        // Back-to-back mul: stall while busy, hold in DONE, issue on ack
        do_reset();
        issue_from_idle(mul4);
        md.dx_insn  = mul9;
        md.dx_valid = 1'b1;
        smp();
        chk("t3_busy_stall", 32'(md.issue_stall), 32'd1);
        chk("t3_busy_ctrl",  32'(md.ctrl_MULT),   32'd0);
        cyc();
        md.data_resultRDY = 1'b1;
        md.data_result    = 32'h77;
        cyc();
        md.data_resultRDY = 1'b0;
        md.data_result    = 32'h0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            smp();
            if (md.wb_req !== 1'b1 || md.wb_rd !== 5'd4 || md.wb_data !== 32'h77 ||
                md.issue_stall !== 1'b1 || md.ctrl_MULT !== 1'b0 || md.inM !== mul4)
                bad++;
            cyc();
        end
        chk("t3_hold_stable", 32'(bad), 32'd0);
        md.wb_ack = 1'b1;
        smp();
        chk("t3_ack_ctrl",  32'(md.ctrl_MULT),   32'd1);
        chk("t3_ack_stall", 32'(md.issue_stall), 32'd0);
        chk("t3_ack_req",   32'(md.wb_req),      32'd1);
        cyc();
        md.wb_ack   = 1'b0;
        md.dx_valid = 1'b0;
        smp();
        chk("t3_new_ong",  32'(md.multOngoing), 32'd1);
        chk("t3_new_inm",  md.inM,              mul9);
        chk("t3_new_req",  32'(md.wb_req),      32'd0);

        // Timeout after exactly 64 BUSY cycles
        do_reset();
        issue_from_idle(div11);
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            smp();
            if (md.wb_req !== 1'b0) bad++;
            cyc();
        end
        chk("t4_no_early_done", 32'(bad), 32'd0);
        smp();
        chk("t4_to_req",  32'(md.wb_req), 32'd1);
        chk("t4_to_rd",   32'(md.wb_rd),  32'd30);
        chk("t4_to_data", md.wb_data,     32'd5);

        // RDY on the 64th BUSY cycle wins over the timeout
        do_reset();
        issue_from_idle(div12);
        repeat (63) cyc();
        md.data_resultRDY = 1'b1;
        md.data_result    = 32'h99;
        smp();
        chk("t4b_busy64_req", 32'(md.wb_req), 32'd0);
        cyc();
        quiet_inputs();
        smp();
        chk("t4b_req",  32'(md.wb_req), 32'd1);
        chk("t4b_rd",   32'(md.wb_rd),  32'd12);
        chk("t4b_data", md.wb_data,     32'h99);

        // Reset during BUSY, late RDY ignored
        do_reset();
        issue_from_idle(mul6);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        smp();
        chk("t5_ong_after_rst", 32'(md.multOngoing), 32'd0);
        cyc();
        md.data_resultRDY = 1'b1;
        md.data_result    = 32'h55;
        cyc();
        md.data_resultRDY = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            smp();
            if (md.wb_req !== 1'b0 || md.multOngoing !== 1'b0) bad++;
            cyc();
        end
        chk("t5_no_wb", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
